// File: rtl/zacore_common.sv
// Shared types for the zacore memory-side blocks: word addresses, the bus
// arbiter state encoding and the memory request bundle.
package zacore_common;

   typedef logic [29:0] word_addr_t;

   typedef enum logic [1:0] {
      ARB_IDLE       = 2'd0,
      ARB_BUSY_FETCH = 2'd1,
      ARB_BUSY_DATA  = 2'd2,
      ARB_BUSY_DROP  = 2'd3
   } arb_state_t;

   typedef struct packed {
      word_addr_t  addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_req_t;

   localparam mem_req_t MEM_REQ_NONE = '0;

   // Instruction fetches are always full-word reads.
   function automatic mem_req_t fetch_req_pack(input word_addr_t addr);
      mem_req_t r;
      r.addr  = addr;
      r.we    = 1'b0;
      r.be    = 4'hF;
      r.wdata = '0;
      return r;
   endfunction

endpackage

// File: rtl/zacore_mem_arbiter.sv
// Shares the single-ported memory bus between fetch and the memory stage.
// Data has priority; a starve counter forces a fetch grant after FETCH_MAX_WAIT.
module zacore_mem_arbiter
   import zacore_common::*;
#(
   parameter int unsigned FETCH_MAX_WAIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_fetch_req,
   output logic        o_fetch_ack,
   input  logic [29:0] i_fetch_addr,
   output logic [31:0] o_inst_read,
   input  logic        i_data_req,
   output logic        o_data_ack,
   input  logic [29:0] i_data_addr,
   input  logic        i_data_we,
   input  logic [3:0]  i_data_be,
   input  logic [31:0] i_data_wdata,
   output logic [31:0] o_data_rdata,
   output logic        o_mem_req,
   input  logic        i_mem_ack,
   output logic [29:0] o_mem_addr,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [3:0] MAX_WAIT = 4'(FETCH_MAX_WAIT);

   arb_state_t state, state_nx;
   logic [3:0] starve;
   mem_req_t   lat, fetch_rq, data_rq, win_rq, bus_rq;
   logic       idle, fetch_win, data_win, mem_req_int;
   logic       fetch_ack_int, data_ack_int;

   always_comb begin
      fetch_rq = fetch_req_pack(i_fetch_addr);
      data_rq  = '{addr: i_data_addr, we: i_data_we, be: i_data_be, wdata: i_data_wdata};
      idle      = (state == ARB_IDLE);
      fetch_win = idle && i_fetch_req && (!i_data_req || starve == MAX_WAIT);
      data_win  = idle && i_data_req && !fetch_win;
      win_rq    = fetch_win ? fetch_rq : (data_win ? data_rq : MEM_REQ_NONE);
      bus_rq    = idle ? win_rq : lat;
      mem_req_int = idle ? (fetch_win || data_win) : 1'b1;
      // A fetch that lets go in the ack cycle no longer wants the word.
      fetch_ack_int = i_mem_ack && (fetch_win || (state == ARB_BUSY_FETCH && i_fetch_req));
      data_ack_int  = i_mem_ack && (data_win || state == ARB_BUSY_DATA);
   end

   always_comb begin
      state_nx = state;
      case (state)
         ARB_IDLE: begin
            if (!i_mem_ack) begin
               if (fetch_win)     state_nx = ARB_BUSY_FETCH;
               else if (data_win) state_nx = ARB_BUSY_DATA;
            end
         end
         ARB_BUSY_FETCH: begin
            if (i_mem_ack)         state_nx = ARB_IDLE;
            else if (!i_fetch_req) state_nx = ARB_BUSY_DROP;
         end
         ARB_BUSY_DATA, ARB_BUSY_DROP: begin
            if (i_mem_ack) state_nx = ARB_IDLE;
         end
         default: state_nx = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= ARB_IDLE;
         starve <= '0;
         lat    <= MEM_REQ_NONE;
      end else begin
         state <= state_nx;
         if (idle && !i_mem_ack && (fetch_win || data_win))
            lat <= win_rq;
         // Only a pending, unserved fetch ages; an in-flight fetch does not.
         if (!i_fetch_req || fetch_win)
            starve <= '0;
         else if (state != ARB_BUSY_FETCH && starve != MAX_WAIT)
            starve <= starve + 4'd1;
      end
   end

   // Outputs are forced quiet while reset is held, even with requests pending.
   assign o_mem_req    = mem_req_int && !i_rst;
   assign o_mem_addr   = i_rst ? '0 : bus_rq.addr;
   assign o_mem_we     = bus_rq.we && !i_rst;
   assign o_mem_be     = i_rst ? '0 : bus_rq.be;
   assign o_mem_wdata  = i_rst ? '0 : bus_rq.wdata;
   assign o_fetch_ack  = fetch_ack_int && !i_rst;
   assign o_data_ack   = data_ack_int && !i_rst;
   assign o_inst_read  = o_fetch_ack ? i_mem_rdata : '0;
   assign o_data_rdata = o_data_ack ? i_mem_rdata : '0;

   a_data_held: assert property (@(posedge i_clk) disable iff (i_rst)
      (state == ARB_BUSY_DATA) |-> i_data_req);
   a_one_ack: assert property (@(posedge i_clk) disable iff (i_rst)
      !(o_fetch_ack && o_data_ack));
   a_ack_mem: assert property (@(posedge i_clk) disable iff (i_rst)
      (o_fetch_ack || o_data_ack) |-> i_mem_ack);

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Directed bench for zacore_mem_arbiter with FETCH_MAX_WAIT = 4.
module tb_zacore_mem_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_fetch_req = 0, i_data_req = 0, i_data_we = 0, i_mem_ack = 0;
   logic [29:0] i_fetch_addr = '0, i_data_addr = '0;
   logic [3:0]  i_data_be = '0;
   logic [31:0] i_data_wdata = '0, i_mem_rdata = '0;
   logic        o_fetch_ack, o_data_ack, o_mem_req, o_mem_we;
   logic [31:0] o_inst_read, o_data_rdata, o_mem_wdata;
   logic [29:0] o_mem_addr;
   logic [3:0]  o_mem_be;

   int passed = 0;
   int total  = 0;

   zacore_mem_arbiter #(.FETCH_MAX_WAIT(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_fetch_req(i_fetch_req), .o_fetch_ack(o_fetch_ack), .i_fetch_addr(i_fetch_addr),
      .o_inst_read(o_inst_read),
      .i_data_req(i_data_req), .o_data_ack(o_data_ack), .i_data_addr(i_data_addr),
      .i_data_we(i_data_we), .i_data_be(i_data_be), .i_data_wdata(i_data_wdata),
      .o_data_rdata(o_data_rdata),
      .o_mem_req(o_mem_req), .i_mem_ack(i_mem_ack), .o_mem_addr(o_mem_addr),
      .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_fetch_req = 0; i_fetch_addr = '0;
      i_data_req = 0; i_data_addr = '0; i_data_we = 0; i_data_be = '0; i_data_wdata = '0;
      i_mem_ack = 0; i_mem_rdata = '0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({o_mem_req, o_fetch_ack, o_data_ack, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata} !== '0)
         $display("FAIL reset_outputs: req=%b fack=%b dack=%b addr=%h required all 0",
                  o_mem_req, o_fetch_ack, o_data_ack, o_mem_addr);
      else passed++;
      @(negedge i_clk);
      i_rst = 0;
      step();
      total++;
      if (dut.state !== 2'd0 || dut.starve !== 4'd0)
         $display("FAIL reset_state: state=%0d starve=%0d required 0/0", dut.state, dut.starve);
      else passed++;
   endtask

   task automatic test_fetch_only();
      i_fetch_req = 1; i_fetch_addr = 30'h10;
      #1;
      total++;
      if (o_mem_req !== 1 || o_mem_addr !== 30'h10 || o_mem_we !== 0 || o_mem_be !== 4'hF || o_fetch_ack !== 0)
         $display("FAIL fetch_grant: req=%b addr=%h we=%b be=%h ack=%b required 1/10/0/f/0",
                  o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_fetch_ack);
      else passed++;
      step();
      total++;
      if (dut.state !== 2'd1 || o_mem_req !== 1 || o_mem_addr !== 30'h10 || o_mem_we !== 0 || o_fetch_ack !== 0)
         $display("FAIL fetch_busy: state=%0d req=%b addr=%h we=%b ack=%b required 1/1/10/0/0",
                  dut.state, o_mem_req, o_mem_addr, o_mem_we, o_fetch_ack);
      else passed++;
      step();
      i_mem_ack = 1; i_mem_rdata = 32'h00000013;
      #1;
      total++;
      if (o_fetch_ack !== 1 || o_inst_read !== 32'h13 || o_data_ack !== 0 || o_data_rdata !== 0)
         $display("FAIL fetch_ack: fack=%b inst=%h dack=%b drd=%h required 1/13/0/0",
                  o_fetch_ack, o_inst_read, o_data_ack, o_data_rdata);
      else passed++;
      step();
      clear_inputs();
      #1;
      total++;
      if (dut.state !== 2'd0 || o_fetch_ack !== 0 || o_inst_read !== 0)
         $display("FAIL fetch_done: state=%0d fack=%b inst=%h required 0/0/0",
                  dut.state, o_fetch_ack, o_inst_read);
      else passed++;
   endtask

   task automatic test_comb_ack();
      i_data_req = 1; i_data_addr = 30'h20; i_data_we = 1; i_data_be = 4'b0011;
      i_data_wdata = 32'hDEADBEEF; i_mem_ack = 1; i_mem_rdata = 32'h55;
      #1;
      total++;
      if (o_data_ack !== 1 || o_mem_we !== 1 || o_mem_be !== 4'b0011 || o_mem_addr !== 30'h20 ||
          o_mem_wdata !== 32'hDEADBEEF || o_fetch_ack !== 0 || o_data_rdata !== 32'h55)
         $display("FAIL comb_ack: dack=%b we=%b be=%h addr=%h wd=%h drd=%h required 1/1/3/20/deadbeef/55",
                  o_data_ack, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_data_rdata);
      else passed++;
      step();
      total++;
      if (dut.state !== 2'd0)
         $display("FAIL comb_ack_state: state=%0d required 0", dut.state);
      else passed++;
      clear_inputs();
      step();
   endtask

   task automatic test_starvation();
      i_fetch_req = 1; i_fetch_addr = 30'h40;
      i_data_req = 1; i_data_addr = 30'h50;
      for (int k = 0; k < 2; k++) begin
         #1;
         total++;
         if (o_mem_addr !== 30'h50 || o_mem_req !== 1 || dut.starve !== 4'(2*k))
            $display("FAIL starve_data_win%0d: addr=%h req=%b starve=%0d required 50/1/%0d",
                     k, o_mem_addr, o_mem_req, dut.starve, 2*k);
         else passed++;
         step();
         i_mem_ack = 1; i_mem_rdata = 32'hA1;
         #1;
         total++;
         if (o_data_ack !== 1 || o_fetch_ack !== 0 || dut.starve !== 4'(2*k+1))
            $display("FAIL starve_data_ack%0d: dack=%b fack=%b starve=%0d required 1/0/%0d",
                     k, o_data_ack, o_fetch_ack, dut.starve, 2*k+1);
         else passed++;
         step();
         i_mem_ack = 0;
      end
      #1;
      total++;
      if (o_mem_addr !== 30'h40 || o_mem_we !== 0 || o_mem_be !== 4'hF || dut.starve !== 4'd4)
         $display("FAIL starve_fetch_win: addr=%h we=%b be=%h starve=%0d required 40/0/f/4",
                  o_mem_addr, o_mem_we, o_mem_be, dut.starve);
      else passed++;
      step();
      i_mem_ack = 1; i_mem_rdata = 32'h11;
      #1;
      total++;
      if (dut.state !== 2'd1 || dut.starve !== 4'd0 || o_fetch_ack !== 1 || o_inst_read !== 32'h11)
         $display("FAIL starve_after_grant: state=%0d starve=%0d fack=%b inst=%h required 1/0/1/11",
                  dut.state, dut.starve, o_fetch_ack, o_inst_read);
      else passed++;
      step();
      i_mem_ack = 0;
      #1;
      total++;
      if (o_mem_addr !== 30'h50 || dut.starve !== 4'd0)
         $display("FAIL starve_data_again: addr=%h starve=%0d required 50/0", o_mem_addr, dut.starve);
      else passed++;
      i_mem_ack = 1;
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_fetch_drop();
      i_fetch_req = 1; i_fetch_addr = 30'h60;
      step();
      i_fetch_req = 0;
      i_data_req = 1; i_data_addr = 30'h70; i_data_we = 1; i_data_be = 4'hF; i_data_wdata = 32'h1234;
      #1;
      total++;
      if (o_mem_req !== 1 || o_mem_addr !== 30'h60 || o_mem_we !== 0 || o_fetch_ack !== 0)
         $display("FAIL drop_busy: req=%b addr=%h we=%b fack=%b required 1/60/0/0",
                  o_mem_req, o_mem_addr, o_mem_we, o_fetch_ack);
      else passed++;
      step();
      total++;
      if (dut.state !== 2'd3 || o_mem_req !== 1 || o_mem_addr !== 30'h60 || o_mem_we !== 0)
         $display("FAIL drop_hold: state=%0d req=%b addr=%h we=%b required 3/1/60/0",
                  dut.state, o_mem_req, o_mem_addr, o_mem_we);
      else passed++;
      step();
      i_mem_ack = 1; i_mem_rdata = 32'hBAD;
      #1;
      total++;
      if (o_fetch_ack !== 0 || o_inst_read !== 0 || o_data_ack !== 0 || o_mem_addr !== 30'h60)
         $display("FAIL drop_ack: fack=%b inst=%h dack=%b addr=%h required 0/0/0/60",
                  o_fetch_ack, o_inst_read, o_data_ack, o_mem_addr);
      else passed++;
      step();
      i_mem_ack = 0;
      #1;
      total++;
      if (dut.state !== 2'd0 || o_mem_req !== 1 || o_mem_addr !== 30'h70 || o_mem_we !== 1)
         $display("FAIL drop_then_data: state=%0d req=%b addr=%h we=%b required 0/1/70/1",
                  dut.state, o_mem_req, o_mem_addr, o_mem_we);
      else passed++;
      i_mem_ack = 1;
      #1;
      total++;
      if (o_data_ack !== 1)
         $display("FAIL drop_data_ack: dack=%b required 1", o_data_ack);
      else passed++;
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_reset_mid_busy();
      i_data_req = 1; i_data_addr = 30'h80; i_data_we = 1; i_data_be = 4'h5; i_data_wdata = 32'hCAFE;
      step();
      total++;
      if (dut.state !== 2'd2)
         $display("FAIL rst_busy_setup: state=%0d required 2", dut.state);
      else passed++;
      #2;
      i_rst = 1; i_mem_ack = 1;
      #1;
      total++;
      if ({o_mem_req, o_data_ack, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata} !== '0 || dut.state !== 2'd0)
         $display("FAIL rst_async: req=%b dack=%b addr=%h we=%b be=%h wd=%h state=%0d required all 0",
                  o_mem_req, o_data_ack, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata, dut.state);
      else passed++;
      clear_inputs();
      @(negedge i_clk);
      i_rst = 0;
      step();
      total++;
      if (dut.state !== 2'd0 || dut.starve !== 4'd0 || o_mem_req !== 0)
         $display("FAIL rst_release: state=%0d starve=%0d req=%b required 0/0/0",
                  dut.state, dut.starve, o_mem_req);
      else passed++;
   endtask

   task automatic test_idle_spurious();
      i_mem_rdata = 32'hFFFFFFFF;
      for (int k = 0; k < 10; k++) begin
         i_mem_ack = (k % 3 == 0);
         #1;
         total++;
         if ({o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata} !== '0 ||
             {o_fetch_ack, o_data_ack} !== 2'b00 || o_inst_read !== 0 || o_data_rdata !== 0)
            $display("FAIL idle_quiet%0d: req=%b addr=%h fack=%b dack=%b required all 0",
                     k, o_mem_req, o_mem_addr, o_fetch_ack, o_data_ack);
         else passed++;
         step();
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_comb_ack();
      test_starvation();
      test_fetch_drop();
      test_reset_mid_busy();
      test_idle_spurious();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
